// File: rtl/cpu7_ifu_fcl_pkg.sv
// Shared fetch-control definitions: FSM state encodings and the
// pc_bf mux select indices also used by the fetch datapath.
package cpu7_ifu_fcl_pkg;

  typedef enum logic [1:0] {
    FCL_ST_INIT  = 2'd0,
    FCL_ST_RUN   = 2'd1,
    FCL_ST_DRAIN = 2'd2
  } fcl_state_e;

  localparam int PCBF_SEL_INIT  = 0;
  localparam int PCBF_SEL_OLD   = 1;
  localparam int PCBF_SEL_PCINC = 2;
  localparam int PCBF_SEL_BRPC  = 3;
  localparam int PCBF_SEL_N     = 4;

endpackage

// File: rtl/cpu7_ifu_fcl_cnt.sv
// Saturation-checked up/down counter with load, used for the
// outstanding-fetch and stale-drop counts.
module cpu7_ifu_fcl_cnt #(
  parameter int W   = 2,
  parameter int MAX = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = load_val;
    else if (inc && !dec)
      cnt_nxt = cnt + W'(1);
    else if (dec && !inc)
      cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  // The counter must never wrap in either direction.
  a_no_ovf: assert property (@(posedge clock) disable iff (reset)
    !(inc && !dec && !load && cnt == W'(MAX)));
  a_no_udf: assert property (@(posedge clock) disable iff (reset)
    !(dec && !inc && !load && cnt == '0));

endmodule

// File: rtl/cpu7_ifu_fcl.sv
// Fetch control: sequences pc_bf selects, icache requests and the
// fetch->decode valid, discarding responses made stale by branches.
module cpu7_ifu_fcl
  import cpu7_ifu_fcl_pkg::*;
#(
  parameter int MAX_OUTST = 1,
  parameter int CNT_W     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inst_addr_ok,
  input  logic inst_valid,
  input  logic br_cancel,
  input  logic exu_ifu_stall_req,
  output logic inst_req,
  output logic inst_cancel,
  output logic fcl_fdp_pcbf_sel_init_bf_l,
  output logic fcl_fdp_pcbf_sel_old_bf_l,
  output logic fcl_fdp_pcbf_sel_pcinc_bf_l,
  output logic fcl_fdp_pcbf_sel_brpc_bf_l,
  output logic fcl_fdp_dec_valid,
  output logic fcl_fdp_pc_f2d_en
);

  fcl_state_e st, st_nxt;

  logic [CNT_W-1:0] oc;
  logic [CNT_W-1:0] dc;
  logic [CNT_W-1:0] dc_ld;
  logic [PCBF_SEL_N-1:0] sel;
  logic live;
  logic br_act;
  logic oc_inc;
  logic oc_dec;
  logic dc_dec;
  logic dc_zero_nxt;
  logic accepted;

  assign live   = (st != FCL_ST_INIT);
  assign br_act = br_cancel & live;

  assign inst_req = live & ~exu_ifu_stall_req &
                    ((oc < CNT_W'(MAX_OUTST)) | inst_valid);
  assign inst_cancel = br_act;

  assign oc_inc = inst_req & inst_addr_ok;
  assign oc_dec = inst_valid & (oc != '0);
  assign dc_dec = inst_valid & (dc != '0) & ~br_act;
  assign dc_ld  = oc - CNT_W'(oc_dec);

  // Whether the drop count will be zero after this edge.
  assign dc_zero_nxt = br_act ? (dc_ld == '0) :
                       ((dc == '0) | ((dc == CNT_W'(1)) & dc_dec));

  assign accepted = inst_valid & (dc == '0) &
                    ~br_cancel & ~exu_ifu_stall_req;

  cpu7_ifu_fcl_cnt #(
    .W   (CNT_W),
    .MAX (MAX_OUTST)
  ) u_oc (
    .clock    (clock),
    .reset    (reset),
    .inc      (oc_inc),
    .dec      (oc_dec),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (oc)
  );

  cpu7_ifu_fcl_cnt #(
    .W   (CNT_W),
    .MAX (MAX_OUTST)
  ) u_dc (
    .clock    (clock),
    .reset    (reset),
    .inc      (1'b0),
    .dec      (dc_dec),
    .load     (br_act),
    .load_val (dc_ld),
    .cnt      (dc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      st <= FCL_ST_INIT;
    else
      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      FCL_ST_INIT:  st_nxt = FCL_ST_RUN;
      FCL_ST_RUN:   if (!dc_zero_nxt) st_nxt = FCL_ST_DRAIN;
      FCL_ST_DRAIN: if (dc_zero_nxt) st_nxt = FCL_ST_RUN;
      default:      st_nxt = FCL_ST_INIT;
    endcase
  end

  always_comb begin
    sel = '0;
    priority case (1'b1)
      !live:             sel[PCBF_SEL_INIT]  = 1'b1;
      br_cancel:         sel[PCBF_SEL_BRPC]  = 1'b1;
      exu_ifu_stall_req: sel[PCBF_SEL_OLD]   = 1'b1;
      accepted:          sel[PCBF_SEL_PCINC] = 1'b1;
      default:           sel[PCBF_SEL_OLD]   = 1'b1;
    endcase
  end

  assign fcl_fdp_pcbf_sel_init_bf_l  = ~sel[PCBF_SEL_INIT];
  assign fcl_fdp_pcbf_sel_old_bf_l   = ~sel[PCBF_SEL_OLD];
  assign fcl_fdp_pcbf_sel_pcinc_bf_l = ~sel[PCBF_SEL_PCINC];
  assign fcl_fdp_pcbf_sel_brpc_bf_l  = ~sel[PCBF_SEL_BRPC];

  assign fcl_fdp_dec_valid = accepted & (st == FCL_ST_RUN);
  assign fcl_fdp_pc_f2d_en = fcl_fdp_dec_valid;

  a_sel_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot(sel));
  a_valid_outst: assert property (@(posedge clock) disable iff (reset)
    !(inst_valid && oc == '0));

endmodule
